control_loop_sequencer: RTL

Initiator-side sequencer for the two-channel PI control loop. For each simulation time step it registers the reference/measurement operand pairs and presents them to the loop. It then pulses the loop start, waits for the loop's done strobe with a cycle-accurate timeout, and captures the two controller outputs. Finally it pulses the valuation strobe so the PI state commits. It sits between the time-step scheduler and the control loop instance.

---
 rtl/control_loop_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/control_loop_sequencer.sv
// Initiator-side sequencer for the two-channel PI control loop: latches operands,
// pulses the loop start, waits for done with a timeout and commits the results.
module control_loop_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  input  logic [63:0] ref_1,
  input  logic [63:0] meas_1,
  input  logic [63:0] ref_2,
  input  logic [63:0] meas_2,
  output logic [63:0] loop_in_1,
  output logic [63:0] loop_in_2,
  output logic [63:0] loop_in_3,
  output logic [63:0] loop_in_4,
  output logic        loop_sta,
  input  logic        loop_done,
  input  logic [63:0] loop_out_1,
  input  logic [63:0] loop_out_2,
  output logic        loop_valuation,
  output logic [63:0] ctrl_1,
  output logic [63:0] ctrl_2,
  output logic        step_done,
  output logic        step_busy,
  output logic        timeout_err,
  output logic [15:0] lat_count
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_now;
  logic [15:0] lat_q, lat_d;
  logic [63:0] in_1_q, in_1_d, in_2_q, in_2_d, in_3_q, in_3_d, in_4_q, in_4_d;
  logic [63:0] ctrl_1_q, ctrl_1_d, ctrl_2_q, ctrl_2_d;
  logic        terr_q, terr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    in_1_d  = in_1_q;
    in_2_d  = in_2_q;
    in_3_d  = in_3_q;
    in_4_d  = in_4_q;
    ctrl_1_d = ctrl_1_q;
    ctrl_2_d = ctrl_2_q;
    terr_d  = terr_q;
    // cnt_now is the count of the current WAIT cycle (first WAIT cycle reads 1)
    cnt_now = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (step_req) begin
          in_1_d  = ref_1;
          in_2_d  = meas_1;
          in_3_d  = ref_2;
          in_4_d  = meas_2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_now;
        // Done in the final allowed cycle still wins over the timeout
        if (loop_done) begin
          ctrl_1_d = loop_out_1;
          ctrl_2_d = loop_out_2;
          lat_d    = cnt_now;
          state_d  = COMMIT;
        end else if (cnt_now == TIMEOUT_C) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      in_1_q   <= '0;
      in_2_q   <= '0;
      in_3_q   <= '0;
      in_4_q   <= '0;
      ctrl_1_q <= '0;
      ctrl_2_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      in_1_q   <= in_1_d;
      in_2_q   <= in_2_d;
      in_3_q   <= in_3_d;
      in_4_q   <= in_4_d;
      ctrl_1_q <= ctrl_1_d;
      ctrl_2_q <= ctrl_2_d;
      terr_q   <= terr_d;
    end
  end

  assign loop_in_1      = in_1_q;
  assign loop_in_2      = in_2_q;
  assign loop_in_3      = in_3_q;
  assign loop_in_4      = in_4_q;
  assign loop_sta       = (state_q == ISSUE);
  assign loop_valuation = (state_q == COMMIT);
  assign step_done      = (state_q == COMMIT);
  assign step_busy      = (state_q != IDLE);
  assign ctrl_1         = ctrl_1_q;
  assign ctrl_2         = ctrl_2_q;
  assign lat_count      = lat_q;
  assign timeout_err    = terr_q;

endmodule
